// File: rtl/fifo_same_clock_thresh.sv
// fifo_same_clock_thresh: single-clock FWFT FIFO. RAM of 2^DATA_DEPTH words
// plus one output register (capacity 2^DATA_DEPTH + 1), with exact fill level,
// registered full/almost flags and sticky overflow/underflow flags.
// Optional high-water mark output enabled by defining FIFO_PEAK_FILL_EN;
// without it peak_fill reads 0 and no peak register exists.
module fifo_same_clock_thresh #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync_clr,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  nempty,
    output logic                  full,
    input  logic [DATA_DEPTH:0]   af_thresh,
    input  logic [DATA_DEPTH:0]   ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  clr_err,
    output logic                  over,
    output logic                  under,
    output logic [DATA_DEPTH:0]   num_in_fifo,
    output logic [DATA_DEPTH:0]   peak_fill
);

    localparam int                CW        = DATA_DEPTH + 1;
    localparam int                RAM_WORDS = 1 << DATA_DEPTH;
    localparam logic [CW-1:0]     RAM_FULL  = CW'(RAM_WORDS);

    logic [DATA_WIDTH-1:0] mem_q [RAM_WORDS];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_DEPTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         ram_cnt_q, ram_cnt_d, count_q, count_d;
    logic                  nempty_q, nempty_d, full_q, full_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  over_q, over_d, under_q, under_d;
    logic                  ram_nempty, wacc, racc, rem;

    // Next-state logic: write/read acceptance, RAM-to-output transfer, counts and flags
    always_comb begin
        ram_nempty = (ram_cnt_q != '0);
        wacc       = we & ~full_q & ~sync_clr;
        racc       = re & nempty_q;
        rem        = ram_nempty & (~nempty_q | re);

        wptr_d     = wptr_q + DATA_DEPTH'(wacc);
        // An empty RAM forces the read pointer back onto the write pointer so a
        // corrupted pointer cannot persist past the next drain.
        rptr_d     = ram_nempty ? (rptr_q + DATA_DEPTH'(rem)) : wptr_q;
        ram_cnt_d  = ram_cnt_q + CW'(wacc) - CW'(rem);
        count_d    = count_q + CW'(wacc) - CW'(racc);
        nempty_d   = rem | (nempty_q & ~racc);
        full_d     = (ram_cnt_d == RAM_FULL);
        data_out_d = rem ? mem_q[rptr_q] : data_out_q;
        // A new error wins over clr_err in the same cycle.
        over_d     = (we & full_q) | (over_q & ~clr_err);
        under_d    = (re & ~nempty_q) | (under_q & ~clr_err);

        if (sync_clr) begin
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
            count_d   = '0;
            nempty_d  = 1'b0;
            full_d    = 1'b0;
            over_d    = 1'b0;
            under_d   = 1'b0;
        end

        // Compare against the next count so the flags line up with num_in_fifo.
        af_d = (count_d >= af_thresh);
        ae_d = (count_d <= ae_thresh);
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            count_q   <= '0;
            nempty_q  <= 1'b0;
            full_q    <= 1'b0;
            af_q      <= (af_thresh == '0);
            ae_q      <= 1'b1;
            over_q    <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            count_q   <= count_d;
            nempty_q  <= nempty_d;
            full_q    <= full_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            over_q    <= over_d;
            under_q   <= under_d;
        end
    end

    // Data storage and output register; contents are qualified by nempty, not reset
    always_ff @(posedge clk) begin
        data_out_q <= data_out_d;
        if (rst_n && wacc) begin
            mem_q[wptr_q] <= data_in;
        end
    end

`ifdef FIFO_PEAK_FILL_EN
    logic [CW-1:0] peak_q, peak_d;

    // High-water mark tracks the next count; clr_err restarts it from the current fill
    always_comb begin
        peak_d = peak_q;
        if (clr_err) begin
            peak_d = count_d;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end
        if (sync_clr) begin
            peak_d = '0;
        end
    end

    // High-water mark register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_fill = peak_q;
`else
    assign peak_fill = '0;
`endif

    assign data_out     = data_out_q;
    assign nempty       = nempty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign over         = over_q;
    assign under        = under_q;
    assign num_in_fifo  = count_q;

endmodule

// File: tb/tb_fifo_same_clock_thresh.sv
// Testbench for fifo_same_clock_thresh (DATA_WIDTH=16, DATA_DEPTH=4).
// Reference model: a queue of (word, write cycle). A word becomes the visible
// head two cycles after its write once everything ahead of it is consumed.
// Written words go to a scoreboard queue that the monitor pops on each read.
module tb_fifo_same_clock_thresh;

    localparam int DW   = 16;
    localparam int DD   = 4;
    localparam int RAMW = 16;

    typedef struct {
        logic [DW-1:0] d;
        int            wc;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n, sync_clr, we, re, clr_err;
    logic [DW-1:0] data_in;
    logic [DD:0]   af_thresh, ae_thresh;
    logic [DW-1:0] data_out;
    logic          nempty, full, almost_full, almost_empty, over, under;
    logic [DD:0]   num_in_fifo, peak_fill;

    ent_t          mq[$];
    logic [DW-1:0] sb_q[$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;
    bit            m_over = 1'b0, m_under = 1'b0;
    int            m_peak = 0;
    int            exp_num = 0, exp_peak = 0;
    bit            exp_nempty, exp_full, exp_af, exp_ae, exp_over, exp_under;

    fifo_same_clock_thresh #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .we(we), .re(re),
        .data_in(data_in), .data_out(data_out), .nempty(nempty), .full(full),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .clr_err(clr_err), .over(over), .under(under),
        .num_in_fifo(num_in_fifo), .peak_fill(peak_fill)
    );

    always #5 clk = ~clk;

    function automatic bit vis_at(input int k);
        return (mq.size() > 0) && (mq[0].wc <= k - 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    // Advance the model by one clock using the inputs applied during this cycle.
    task automatic model_update();
        int thr_af = int'(af_thresh);
        int thr_ae = int'(ae_thresh);
        if (!rst_n || sync_clr) begin
            mq.delete();
            sb_q.delete();
            m_over  = 1'b0;
            m_under = 1'b0;
            m_peak  = 0;
        end else begin
            bit   v  = vis_at(cyc);
            bit   f  = (mq.size() - int'(v)) == RAMW;
            bit   wa = we && !f;
            bit   ra = re && v;
            ent_t e;
            m_over  = (we && f) || (m_over && !clr_err);
            m_under = (re && !v) || (m_under && !clr_err);
            if (ra) void'(mq.pop_front());
            if (wa) begin
                e.d  = data_in;
                e.wc = cyc;
                mq.push_back(e);
                sb_q.push_back(data_in);
            end
            if (clr_err) m_peak = mq.size();
            else if (mq.size() > m_peak) m_peak = mq.size();
        end
        cyc++;
        exp_num    = mq.size();
        exp_nempty = vis_at(cyc);
        exp_full   = (mq.size() - int'(exp_nempty)) == RAMW;
        exp_af     = mq.size() >= thr_af;
        exp_ae     = mq.size() <= thr_ae;
        exp_over   = m_over;
        exp_under  = m_under;
`ifdef FIFO_PEAK_FILL_EN
        exp_peak   = m_peak;
`else
        exp_peak   = 0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
        we      = w;
        re      = r;
        data_in = d;
        step();
    endtask

    // Monitor: compare status against the model and pop the scoreboard on each read
    always @(negedge clk) begin
        if (chk_en) begin
            logic [DW-1:0] d;
            chk("num_in_fifo", 32'(num_in_fifo), 32'(exp_num));
            chk("nempty", 32'(nempty), 32'(exp_nempty));
            chk("full", 32'(full), 32'(exp_full));
            chk("almost_full", 32'(almost_full), 32'(exp_af));
            chk("almost_empty", 32'(almost_empty), 32'(exp_ae));
            chk("over", 32'(over), 32'(exp_over));
            chk("under", 32'(under), 32'(exp_under));
            chk("peak_fill", 32'(peak_fill), 32'(exp_peak));
            if (nempty && re) begin
                if (sb_q.size() == 0) begin
                    chk("read_with_nothing_expected", 32'(nempty), 32'd0);
                end else begin
                    d = sb_q.pop_front();
                    chk("data_out", 32'(data_out), 32'(d));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; sync_clr = 1'b0; we = 1'b0; re = 1'b0; clr_err = 1'b0;
        data_in = '0; af_thresh = 5'd12; ae_thresh = 5'd3;
        step();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;

        // Fill to capacity, one refused write, then drain in order and over-read
        for (int i = 1; i <= 17; i++) drive(1'b1, 1'b0, DW'(i));
        drive(1'b1, 1'b0, 16'h0012);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0);
        for (int i = 0; i < 17; i++) drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b1, '0);
        clr_err = 1'b1;
        drive(1'b0, 1'b0, '0);
        clr_err = 1'b0;

        // Single-word latency and read-back
        drive(1'b1, 1'b0, 16'hA5A5);
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);

        // Steady fill of 5 with simultaneous write/read across pointer wrap
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'($urandom));
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, DW'($urandom));
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, '0);

        // High-water mark: fill to 9, drain to 2, restart with clr_err
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, DW'($urandom));
        drive(1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, '0);
        clr_err = 1'b1;
        drive(1'b0, 1'b0, '0);
        clr_err = 1'b0;
        drive(1'b0, 1'b0, '0);

        // Flush in the middle of a write burst
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, DW'($urandom));
        sync_clr = 1'b1;
        drive(1'b1, 1'b1, DW'($urandom));
        sync_clr = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, '0);

        // Randomised traffic with varying rates, thresholds, flushes and resets
        for (int blk = 0; blk < 15; blk++) begin
            int pw = $urandom_range(10, 95);
            int pr = $urandom_range(10, 95);
            for (int i = 0; i < 200; i++) begin
                clr_err  = ($urandom_range(0, 99) < 2);
                sync_clr = ($urandom_range(0, 199) == 0);
                rst_n    = !($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 99) < 3) af_thresh = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 99) < 3) ae_thresh = 5'($urandom_range(0, 31));
                drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, DW'($urandom));
            end
        end
        clr_err = 1'b0; sync_clr = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, '0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_same_clock_thresh.md
Name: fifo_same_clock_thresh

Overview:
- Parametrised single-clock FIFO with first-word-fall-through output register.
- Reports an exact fill level, full/empty flags and runtime-programmable almost-full/almost-empty flags, with sticky overflow/underflow error flags.
- Drop-in successor for buffer/flow-control paths such as AXI address/data staging and sensor/compressor channel buffers, where producers need early back-pressure.

Parameters:
- DATA_WIDTH, 16, data word width.
- DATA_DEPTH, 4, log2 of RAM depth; RAM holds 2^DATA_DEPTH words. Total capacity CAP = 2^DATA_DEPTH + 1, counting the output register.

Ports:
- clk  input  1  clock, positive edge.
- rst_n  input  1  reset, synchronous, active-low.
- sync_clr  input  1  synchronous flush, active high; same effect as reset except af_thresh/ae_thresh, which are inputs.
- we  input  1  write strobe.
- re  input  1  read/acknowledge strobe for the current data_out.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  head word; valid while nempty.
- nempty  output  1  output register holds a valid word.
- full  output  1  RAM holds 2^DATA_DEPTH words; writes are refused.
- af_thresh  input  DATA_DEPTH+1  almost-full threshold.
- ae_thresh  input  DATA_DEPTH+1  almost-empty threshold.
- almost_full  output  1  num_in_fifo >= af_thresh.
- almost_empty  output  1  num_in_fifo <= ae_thresh.
- clr_err  input  1  clears the sticky over/under flags.
- over  output  1  sticky: write attempted while full.
- under  output  1  sticky: read attempted while !nempty.
- num_in_fifo  output  DATA_DEPTH+1  words held, RAM plus output register, range 0..CAP.
- peak_fill  output  DATA_DEPTH+1  high-water mark (optional feature).

Behaviour:
- Reset (rst_n=0 at clk edge) or sync_clr=1, same edge:
  - num_in_fifo=0, nempty=0, full=0, over=0, under=0, peak_fill=0.
  - almost_empty=1 (0<=ae_thresh). almost_full=1 only if af_thresh==0.
  - data_out value undefined.
  - Reset takes priority over all other inputs; a mid-operation reset or flush discards contents with no partial words left.
- Write acceptance: wacc = we & !full.
  - Write when full is dropped: RAM unchanged, over set next cycle. This holds even with a simultaneous re.
- RAM-to-output transfer: rem = ram_nempty & (!nempty | re).
- Read acknowledge: racc = re & nempty. re with !nempty is ignored and sets under next cycle.
- Latency:
  - Word written with we at cycle 0 into an empty FIFO: nempty=1 and data_out valid at cycle 2.
  - Back-to-back reads sustain 1 word/clk.
- Ordering: strict FIFO order; pointers wrap modulo 2^DATA_DEPTH with no gap.
- num_in_fifo: next = cur + wacc - racc, registered.
  - Simultaneous accepted write and read leaves it unchanged.
  - Never exceeds CAP and never underflows.
- full is registered: asserted exactly when RAM count reaches 2^DATA_DEPTH, deasserted the cycle after rem frees a slot.
- almost_full and almost_empty are registered from the next-state num_in_fifo compared with the current thresholds. This keeps them coincident with num_in_fifo.
  - A threshold change takes effect on the next edge.
  - af_thresh > CAP means almost_full is never set.
- over/under: set on error, hold until clr_err or reset. Set has priority over clr_err in the same cycle.
- Internal read pointer resyncs to the write pointer whenever the RAM is empty, as a single-event-upset recovery measure.

Optional Feature:
- Macro FIFO_PEAK_FILL_EN.
- Defined:
  - peak_fill = max num_in_fifo seen since reset or since a clr_err pulse; clr_err loads the current num_in_fifo.
  - Updated with the same timing as num_in_fifo.
- Undefined: peak_fill tied to 0 and no peak register is generated.

Test Plan:
- Reset, DATA_DEPTH=4 -> num_in_fifo=0, nempty=0, full=0, almost_empty=1, over=under=0.
- Write 0x0001..0x0011 (17 words), no reads -> num_in_fifo=17, full=1, nempty=1, data_out=0x0001. An 18th write sets over=1; reading all 17 returns 0x0001..0x0011 in order.
- Single write 0xA5A5 at cycle 0 into empty FIFO -> nempty=1, data_out=0xA5A5 at cycle 2. re at cycle 2 -> nempty=0 at cycle 3.
- Continuous we&re for 40 cycles at fill 5 -> num_in_fifo stays 5 and output sequence is contiguous across pointer wrap.
- af_thresh=12, ae_thresh=3: fill from 0 to 12 -> almost_full rises coincident with num_in_fifo=12; almost_empty drops at num_in_fifo=4. re on empty FIFO -> under=1; clr_err -> under=0.
- FIFO_PEAK_FILL_EN defined: fill to 9, drain to 2 -> peak_fill=9; clr_err -> peak_fill=2. sync_clr mid-burst -> all counts 0 on the next cycle.
